// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code conversion arbiter.
package gray_pkg;

  localparam int GRAY_WIDTH_DEF = 4;
  localparam int N_REQ_MAX      = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Operates on a 32-bit container; callers truncate to their own width.
  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray converter with select flag Y.
// Shared by all requesters behind the operand mux.
module gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] g_o,
  output logic             y_o
);

  assign g_o = WIDTH'(bin_to_gray(32'(b_i)));

  generate
    if (WIDTH >= 4) begin : g_flag
      logic s;
      assign s   = b_i[3] & b_i[0];
      assign y_o = s ? b_i[2] : b_i[1];
    end else begin : g_no_flag
      // Y is undefined for narrow words; tie it off.
      assign y_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray converter between N_REQ requesters,
// with a single registered output slot. Define GRAY_STATS_EN for grant counters.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF,
  parameter int N_REQ = 2,
  parameter int RID_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_B,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_G,
  output logic                   out_Y,
  output logic [RID_W-1:0]       out_rid
`ifdef GRAY_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [N_REQ*8-1:0]     grant_cnt
`endif
);

  slot_state_e      slot_q, slot_d;
  logic [RID_W-1:0] rr_q, rr_d;
  logic [RID_W-1:0] rid_q, rid_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             y_q, y_d;

  logic [WIDTH-1:0] b_arr [N_REQ];
  logic             found, slot_free, grant;
  logic [RID_W-1:0] sel;
  logic [WIDTH-1:0] sel_b, enc_g;
  logic             enc_y;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign b_arr[gi] = req_B[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Two passes: indices at/above the pointer first, then the wrapped part.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[k] && (k >= int'(rr_q))) begin
        found = 1'b1;
        sel   = RID_W'(k);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[k]) begin
        found = 1'b1;
        sel   = RID_W'(k);
      end
    end
  end

  assign slot_free = (slot_q == SLOT_EMPTY) | out_ready;
  assign grant     = found & slot_free & ~rst;

  always_comb begin
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel == RID_W'(k)) sel_b = b_arr[k];
    end
  end

  gray_enc #(.WIDTH(WIDTH)) u_enc (
    .b_i (sel_b),
    .g_o (enc_g),
    .y_o (enc_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= SLOT_EMPTY;
      rr_q   <= '0;
      rid_q  <= '0;
      g_q    <= '0;
      y_q    <= 1'b0;
    end else begin
      slot_q <= slot_d;
      rr_q   <= rr_d;
      rid_q  <= rid_d;
      g_q    <= g_d;
      y_q    <= y_d;
    end
  end

  always_comb begin
    slot_d = slot_q;
    rr_d   = rr_q;
    rid_d  = rid_q;
    g_d    = g_q;
    y_d    = y_q;
    if (grant) begin
      slot_d = SLOT_FULL;
      g_d    = enc_g;
      y_d    = enc_y;
      rid_d  = sel;
      rr_d   = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
    end else if ((slot_q == SLOT_FULL) && out_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    out_valid = (slot_q == SLOT_FULL);
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant && (sel == RID_W'(k))) req_ready[k] = 1'b1;
    end
  end

  assign out_G   = g_q;
  assign out_Y   = y_q;
  assign out_rid = rid_q;

`ifdef GRAY_STATS_EN
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cnt
      logic [7:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (stats_clr)
          cnt_d = '0;
        else if (req_ready[gi] && req_valid[gi] && (cnt_q != 8'hFF))
          cnt_d = cnt_q + 8'd1;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign grant_cnt[gi*8 +: 8] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter (WIDTH=4, N_REQ=2).
module tb_gray_conv_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_B;
  logic [1:0] req_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_G;
  logic       out_Y;
  logic [1:0] out_rid;
`ifdef GRAY_STATS_EN
  logic        stats_clr;
  logic [15:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_conv_arbiter #(.WIDTH(4), .N_REQ(2), .RID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_B     (req_B),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_G     (out_G),
    .out_Y     (out_Y),
    .out_rid   (out_rid)
`ifdef GRAY_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One isolated transaction from requester r, then a drain cycle.
  task automatic single(input int r, input logic [3:0] b, input logic [3:0] eg, input logic ey);
    req_B            = '0;
    req_B[r*4 +: 4]  = b;
    req_valid        = 2'(1 << r);
    out_ready        = 1'b1;
    #1 check("single_ready", req_ready, 32'(1 << r));
    @(posedge clk); #1;
    req_valid = '0;
    check("single_valid", out_valid, 1);
    check("single_G", out_G, eg);
    check("single_Y", out_Y, ey);
    check("single_rid", out_rid, r);
    @(posedge clk); #1;
    check("drain_valid", out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_B     = '0;
    out_ready = 1'b0;
`ifdef GRAY_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_G", out_G, 0);
    check("rst_Y", out_Y, 0);
    check("rst_rid", out_rid, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;

    // Single request and flag coverage; rr goes 1,0,1,0
    single(0, 4'b1011, 4'b1110, 1'b0);
    single(1, 4'b0110, 4'b0101, 1'b1);
    single(0, 4'b1101, 4'b1011, 1'b1);
    single(1, 4'b1001, 4'b1101, 1'b0);

    // Fairness: both requesters always valid, consumer always ready
    req_B     = {4'b1101, 4'b0110};
    req_valid = 2'b11;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("fair_ready", req_ready, (i % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
      check("fair_valid", out_valid, 1);
      check("fair_rid", out_rid, i % 2);
      check("fair_G", out_G, (i % 2 == 0) ? 32'h5 : 32'hB);
    end

    // Backpressure: slot holds rid 1 / G=1011, rr=0
    out_ready = 1'b0;
    #1 check("stall_ready", req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_ready", req_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_G", out_G, 4'b1011);
      check("stall_Y", out_Y, 1);
      check("stall_rid", out_rid, 1);
    end
    out_ready = 1'b1;
    #1 check("release_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    check("release_rid", out_rid, 0);
    check("release_G", out_G, 4'b0101);
    check("release_valid", out_valid, 1);

    // Async reset in the middle of a stall (rr is 1 before reset)
    out_ready = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_G", out_G, 0);
    check("arst_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("post_rst_ready", req_ready, 2'b01);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rid", out_rid, 0);
    check("post_rst_valid", out_valid, 1);

`ifdef GRAY_STATS_EN
    req_valid = 2'b10;
    repeat (300) @(posedge clk);
    #1;
    check("cnt1_sat", grant_cnt[15:8], 255);
    check("cnt0", grant_cnt[7:0], 1);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    req_valid = '0;
    check("cnt_clr", grant_cnt, 0);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = '0;
    check("cnt_after_clr", grant_cnt, 16'h0001);
`endif

    req_valid = '0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
